// File: rtl/udp_payload_extractor.sv
// udp_payload_extractor
// Parses the Ethernet/IPv4/UDP headers of a received frame byte stream.
// Frames that pass every header check and match DST_PORT have their UDP
// payload forwarded as a byte stream. All other frames are dropped and counted.
//
// Handshake: the input side uses rxDataValidIn to qualify rxDataIn. rxDataLastIn
// has meaning only when valid is high. There is no back-pressure in either
// direction. payloadValidOut qualifies payloadOut, and payloadLastOut and
// payloadErrOut are high only in the same cycle as payloadValidOut.
module udp_payload_extractor #(
  parameter logic [15:0] DST_PORT = 16'd5000
) (
  input  logic        rxClkIn,
  input  logic        rstBIn,
  input  logic [7:0]  rxDataIn,
  input  logic        rxDataValidIn,
  input  logic        rxDataLastIn,
  output logic [7:0]  payloadOut,
  output logic        payloadValidOut,
  output logic        payloadLastOut,
  output logic        payloadErrOut,
  output logic        dropOut,
  output logic [15:0] goodCntOut,
  output logic [15:0] dropCntOut,
  output logic [1:0]  stateDbgOut
);

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [5:0] IDX_MAX = 6'd42;

  state_t      state;
  logic [5:0]  idx;
  logic [7:0]  prev_byte;
  logic [15:0] csum;
  logic [15:0] udp_len;
  logic [15:0] remain;

  logic [15:0] word;
  logic [15:0] csum_base;
  logic [16:0] csum_wide;
  logic [15:0] csum_next;
  logic        csum_word;
  logic        hdr_fail;
  logic        hdr_runt;

  // Header checks on the current byte. A 16-bit field is judged on its second byte.
  always_comb begin
    word      = {prev_byte, rxDataIn};
    csum_base = (idx == 6'd15) ? 16'h0000 : csum;
    csum_wide = {1'b0, csum_base} + {1'b0, word};
    csum_next = csum_wide[15:0] + {15'd0, csum_wide[16]};
    csum_word = idx[0] && (idx >= 6'd15) && (idx <= 6'd33);
    hdr_fail  = 1'b0;
    case (idx)
      6'd13:   hdr_fail = (word != 16'h0800);
      6'd14:   hdr_fail = (rxDataIn != 8'h45);
      6'd23:   hdr_fail = (rxDataIn != 8'h11);
      6'd33:   hdr_fail = (csum_next != 16'hFFFF);
      6'd37:   hdr_fail = (word != DST_PORT);
      6'd39:   hdr_fail = (word < 16'd8);
      default: hdr_fail = 1'b0;
    endcase
    // A zero-length datagram may legitimately end on its last header byte.
    hdr_runt = rxDataLastIn && !((idx == 6'd41) && (udp_len == 16'd8));
  end

  // Parser FSM with registered payload, drop and counter outputs
  always_ff @(posedge rxClkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      state           <= HDR;
      idx             <= 6'd0;
      prev_byte       <= 8'h00;
      csum            <= 16'h0000;
      udp_len         <= 16'h0000;
      remain          <= 16'h0000;
      payloadOut      <= 8'h00;
      payloadValidOut <= 1'b0;
      payloadLastOut  <= 1'b0;
      payloadErrOut   <= 1'b0;
      dropOut         <= 1'b0;
      goodCntOut      <= 16'h0000;
      dropCntOut      <= 16'h0000;
    end else begin
      payloadValidOut <= 1'b0;
      payloadLastOut  <= 1'b0;
      payloadErrOut   <= 1'b0;
      dropOut         <= 1'b0;
      if (rxDataValidIn) begin
        prev_byte <= rxDataIn;
        if (rxDataLastIn) begin
          idx <= 6'd0;
        end else if (idx != IDX_MAX) begin
          idx <= idx + 6'd1;
        end
        case (state)
          HDR: begin
            if (csum_word) begin
              csum <= csum_next;
            end
            if (idx == 6'd39) begin
              udp_len <= word;
            end
            if (hdr_fail || hdr_runt) begin
              dropOut    <= 1'b1;
              dropCntOut <= dropCntOut + 16'd1;
              state      <= rxDataLastIn ? HDR : DRAIN;
            end else if (idx == 6'd41) begin
              if (udp_len == 16'd8) begin
                goodCntOut <= goodCntOut + 16'd1;
                state      <= rxDataLastIn ? HDR : DRAIN;
              end else begin
                remain <= udp_len - 16'd8;
                state  <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            payloadOut      <= rxDataIn;
            payloadValidOut <= 1'b1;
            remain          <= remain - 16'd1;
            if (remain == 16'd1) begin
              payloadLastOut <= 1'b1;
              goodCntOut     <= goodCntOut + 16'd1;
              state          <= rxDataLastIn ? HDR : DRAIN;
            end else if (rxDataLastIn) begin
              payloadLastOut <= 1'b1;
              payloadErrOut  <= 1'b1;
              dropCntOut     <= dropCntOut + 16'd1;
              state          <= HDR;
            end
          end
          DRAIN: begin
            if (rxDataLastIn) begin
              state <= HDR;
            end
          end
          default: state <= HDR;
        endcase
      end
    end
  end

  assign stateDbgOut = state;

endmodule
